// File: rtl/branch_predictor_gshare.sv
// -----------------------------------------------------------------------------
// branch_predictor_gshare
//
// Gshare conditional-branch predictor. A table of 2^INDEX_BITS saturating
// counters is indexed by the low PC bits XORed with a global history register
// (GHR). Lookups return the counter MSB one cycle later and speculatively shift
// the predicted direction into the GHR. Resolved branches train the counter
// they were predicted from (the caller returns the history snapshot with the
// branch), and a mispredicted branch rebuilds the GHR from that snapshot plus
// the real outcome.
//
// Strobe semantics: lookup_valid and update_valid are single-cycle strobes
// with no back-pressure. A strobe is consumed at the rising edge where it is
// high and en is high; there is no ready signal because the block accepts
// one lookup and one update every cycle. pred_valid is a one-cycle strobe
// that marks the cycle in which pred_taken/pred_hist belong to the lookup
// accepted at the previous edge; those two outputs hold between strobes.
//
// Ports
//   clk               clock, all state changes on the rising edge
//   arst              asynchronous active-high reset
//   en                global enable; when low nothing changes, pred_valid drops
//   lookup_valid      prediction request strobe
//   lookup_pc         low PC bits of the request
//   pred_valid        registered prediction strobe (latency 1)
//   pred_taken        registered prediction (counter MSB)
//   pred_hist         GHR value that formed the lookup index
//   update_valid      branch resolution strobe
//   update_pc         low PC bits of the resolved branch
//   update_hist       pred_hist that came back with the branch
//   update_taken      resolved direction
//   update_mispredict resolved direction differed from the prediction
// -----------------------------------------------------------------------------
module branch_predictor_gshare #(
    parameter int INDEX_BITS = 5,
    parameter int CTR_BITS   = 2,
    parameter int HIST_BITS  = 5,
    parameter int CTR_INIT   = (1 << (CTR_BITS - 1)) - 1
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  en,
    input  logic                  lookup_valid,
    input  logic [INDEX_BITS-1:0] lookup_pc,
    output logic                  pred_valid,
    output logic                  pred_taken,
    output logic [HIST_BITS-1:0]  pred_hist,
    input  logic                  update_valid,
    input  logic [INDEX_BITS-1:0] update_pc,
    input  logic [HIST_BITS-1:0]  update_hist,
    input  logic                  update_taken,
    input  logic                  update_mispredict
);

    localparam int                ENTRIES = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(CTR_INIT);

    logic [CTR_BITS-1:0]   ctr [ENTRIES];
    logic [HIST_BITS-1:0]  ghr;
    logic [HIST_BITS-1:0]  ghr_spec;
    logic [HIST_BITS-1:0]  ghr_restore;
    logic [HIST_BITS-1:0]  ghr_next;

    logic [INDEX_BITS-1:0] lookup_idx;
    logic [INDEX_BITS-1:0] update_idx;
    logic                  lookup_fire;
    logic                  update_fire;
    logic                  restore_fire;
    logic                  lookup_bit;
    logic [CTR_BITS-1:0]   upd_cur;
    logic [CTR_BITS-1:0]   upd_next;

    // ------------------------------------------------------------------
    // Qualification and indexing
    // ------------------------------------------------------------------
    assign lookup_fire  = en & lookup_valid;
    assign update_fire  = en & update_valid;
    // A mispredict flag without update_valid carries no meaning.
    assign restore_fire = update_fire & update_mispredict;

    // History is narrower than or equal to the index; the cast zero-extends.
    assign lookup_idx = lookup_pc ^ INDEX_BITS'(ghr);
    assign update_idx = update_pc ^ INDEX_BITS'(update_hist);

    // Table read happens before any write at this edge, so a lookup and an
    // update hitting the same entry see the old counter.
    assign lookup_bit = ctr[lookup_idx][CTR_BITS-1];

    // ------------------------------------------------------------------
    // GHR candidates: speculative shift vs. repair from the snapshot
    // ------------------------------------------------------------------
    generate
        if (HIST_BITS == 1) begin : g_hist_one
            assign ghr_spec    = lookup_bit;
            assign ghr_restore = update_taken;
        end else begin : g_hist_wide
            assign ghr_spec    = {ghr[HIST_BITS-2:0], lookup_bit};
            assign ghr_restore = {update_hist[HIST_BITS-2:0], update_taken};
        end
    endgenerate

    // Repair wins over a same-edge speculative shift: the lookup was made on
    // a wrong path, so its shifted bit is dropped.
    always_comb begin
        ghr_next = ghr;
        if (restore_fire) begin
            ghr_next = ghr_restore;
        end else if (lookup_fire) begin
            ghr_next = ghr_spec;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            ghr <= '0;
        end else begin
            ghr <= ghr_next;
        end
    end

    // ------------------------------------------------------------------
    // Counter training: saturating, never wraps
    // ------------------------------------------------------------------
    always_comb begin
        upd_cur  = ctr[update_idx];
        upd_next = upd_cur;
        if (update_taken) begin
            if (upd_cur != CTR_MAX) begin
                upd_next = upd_cur + CTR_BITS'(1);
            end
        end else begin
            if (upd_cur != '0) begin
                upd_next = upd_cur - CTR_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= CTR_RST;
            end
        end else if (update_fire) begin
            ctr[update_idx] <= upd_next;
        end
    end

    // ------------------------------------------------------------------
    // Prediction outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_hist  <= '0;
        end else begin
            pred_valid <= lookup_fire;
            if (lookup_fire) begin
                pred_taken <= lookup_bit;
                pred_hist  <= ghr;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor_gshare
//
// Directed bench for branch_predictor_gshare at default parameters
// (32 entries, 2-bit counters reset to 1, 5-bit history). Expected
// predictions are worked out by hand and queued as {taken, hist}; each
// prediction cycle pops one entry and compares.
// -----------------------------------------------------------------------------
module tb_branch_predictor_gshare;

    localparam int INDEX_BITS = 5;
    localparam int CTR_BITS   = 2;
    localparam int HIST_BITS  = 5;
    localparam int W          = HIST_BITS + 1;

    logic                  clk;
    logic                  arst;
    logic                  en;
    logic                  lookup_valid;
    logic [INDEX_BITS-1:0] lookup_pc;
    logic                  pred_valid;
    logic                  pred_taken;
    logic [HIST_BITS-1:0]  pred_hist;
    logic                  update_valid;
    logic [INDEX_BITS-1:0] update_pc;
    logic [HIST_BITS-1:0]  update_hist;
    logic                  update_taken;
    logic                  update_mispredict;

    logic [W-1:0] exp_q[$];
    int n_checks;
    int n_errors;

    branch_predictor_gshare #(
        .INDEX_BITS(INDEX_BITS),
        .CTR_BITS  (CTR_BITS),
        .HIST_BITS (HIST_BITS)
    ) dut (
        .clk              (clk),
        .arst             (arst),
        .en               (en),
        .lookup_valid     (lookup_valid),
        .lookup_pc        (lookup_pc),
        .pred_valid       (pred_valid),
        .pred_taken       (pred_taken),
        .pred_hist        (pred_hist),
        .update_valid     (update_valid),
        .update_pc        (update_pc),
        .update_hist      (update_hist),
        .update_taken     (update_taken),
        .update_mispredict(update_mispredict)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp_v);
        end
    endtask

    // Pops the next queued prediction and compares it with the outputs.
    task automatic check_pred(input string tag);
        logic [W-1:0] e;
        check({tag, "_qlen"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_valid"}, 32'(pred_valid), 32'd1);
            check({tag, "_taken"}, 32'(pred_taken), 32'(e[W-1]));
            check({tag, "_hist"},  32'(pred_hist),  32'(e[HIST_BITS-1:0]));
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        en                = 1'b1;
        lookup_valid      = 1'b0;
        lookup_pc         = '0;
        update_valid      = 1'b0;
        update_pc         = '0;
        update_hist       = '0;
        update_taken      = 1'b0;
        update_mispredict = 1'b0;
    endtask

    task automatic drive_update(input logic [INDEX_BITS-1:0] pc, input logic [HIST_BITS-1:0] hist,
                                input logic taken, input logic mis);
        update_valid      = 1'b1;
        update_pc         = pc;
        update_hist       = hist;
        update_taken      = taken;
        update_mispredict = mis;
        tick();
        set_idle();
    endtask

    task automatic drive_lookup(input string tag, input logic [INDEX_BITS-1:0] pc,
                                input logic exp_taken, input logic [HIST_BITS-1:0] exp_hist);
        lookup_valid = 1'b1;
        lookup_pc    = pc;
        exp_q.push_back({exp_taken, exp_hist});
        tick();
        set_idle();
        check_pred(tag);
    endtask

    // Reset asserted mid-cycle, checked while held, released mid-cycle.
    task automatic do_reset(input string tag);
        #2 arst = 1'b1;
        #1;
        check({tag, "_rst_valid"}, 32'(pred_valid), 32'd0);
        check({tag, "_rst_taken"}, 32'(pred_taken), 32'd0);
        check({tag, "_rst_hist"},  32'(pred_hist),  32'd0);
        tick();
        #3 arst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        arst     = 1'b1;
        set_idle();
        #2;
        check("por_valid", 32'(pred_valid), 32'd0);
        check("por_taken", 32'(pred_taken), 32'd0);
        check("por_hist",  32'(pred_hist),  32'd0);
        tick();
        #3 arst = 1'b0;

        // A: first edge after reset handles a lookup; counter 1 -> not taken.
        drive_lookup("a_lk3", 5'd3, 1'b0, 5'b00000);
        tick();
        check("a_idle_valid", 32'(pred_valid), 32'd0);

        // B: saturation at both ends on entry 4 (updates carry no mispredict).
        do_reset("b");
        repeat (3) drive_update(5'd4, 5'd0, 1'b1, 1'b0);            // 2,3,3
        drive_lookup("b_lk_sat_hi", 5'd4, 1'b1, 5'b00000);          // GHR -> 00001
        tick();
        check("b_hold_valid", 32'(pred_valid), 32'd0);
        check("b_hold_taken", 32'(pred_taken), 32'd1);
        repeat (2) drive_update(5'd4, 5'd0, 1'b0, 1'b0);            // 2,1
        drive_lookup("b_lk_dec", 5'd5, 1'b0, 5'b00001);             // idx 4, GHR -> 00010
        check("b_hold_hist", 32'(pred_hist), 32'd1);
        repeat (3) drive_update(5'd4, 5'd0, 1'b0, 1'b0);            // 0,0,0
        repeat (2) drive_update(5'd4, 5'd0, 1'b1, 1'b0);            // 1,2
        drive_lookup("b_lk_sat_lo", 5'd6, 1'b1, 5'b00010);          // idx 4

        // C: speculative history shifting.
        do_reset("c");
        drive_update(5'd2, 5'd0, 1'b1, 1'b0);                       // ctr[2]=2
        drive_lookup("c_lk2", 5'd2, 1'b1, 5'b00000);                // GHR -> 00001
        drive_lookup("c_lk4", 5'd4, 1'b0, 5'b00001);                // idx 5, GHR -> 00010
        drive_lookup("c_lk0", 5'd0, 1'b1, 5'b00010);                // idx 2

        // D: same-edge lookup and mispredict repair; repair wins.
        do_reset("d");
        lookup_valid      = 1'b1;
        lookup_pc         = 5'd7;
        update_valid      = 1'b1;
        update_pc         = 5'd0;
        update_hist       = 5'b00101;
        update_taken      = 1'b1;
        update_mispredict = 1'b1;                                   // ctr[5]=2, GHR -> 01011
        exp_q.push_back({1'b0, 5'b00000});
        tick();
        set_idle();
        check_pred("d_same_edge");
        drive_lookup("d_after_fix", 5'd14, 1'b1, 5'b01011);         // idx 5, GHR -> 10111
        // Mispredict without update_valid must not touch the GHR.
        update_mispredict = 1'b1;
        update_taken      = 1'b0;
        update_hist       = 5'b00000;
        tick();
        set_idle();
        drive_lookup("d_mis_noval", 5'd0, 1'b0, 5'b10111);          // idx 23

        // E: lookup and update to the same entry at the same edge.
        do_reset("e");
        lookup_valid = 1'b1;
        lookup_pc    = 5'd9;
        update_valid = 1'b1;
        update_pc    = 5'd9;
        update_taken = 1'b1;                                        // ctr[9] 1 -> 2
        exp_q.push_back({1'b0, 5'b00000});
        tick();
        set_idle();
        check_pred("e_rbw");
        drive_lookup("e_after", 5'd9, 1'b1, 5'b00000);              // GHR -> 00001

        // F: en=0 freezes everything even with strobes active.
        en                = 1'b0;
        lookup_valid      = 1'b1;
        lookup_pc         = 5'd3;
        update_valid      = 1'b1;
        update_pc         = 5'd9;
        update_hist       = 5'b00000;
        update_taken      = 1'b0;
        update_mispredict = 1'b1;
        tick();
        check("f_en0_valid", 32'(pred_valid), 32'd0);
        check("f_en0_taken", 32'(pred_taken), 32'd1);
        check("f_en0_hist",  32'(pred_hist),  32'd0);
        set_idle();
        drive_lookup("f_after", 5'd8, 1'b1, 5'b00001);              // idx 9, GHR -> 00011

        // G: reset during back-to-back lookups.
        lookup_valid = 1'b1;
        lookup_pc    = 5'd0;
        exp_q.push_back({1'b0, 5'b00011});                          // idx 3
        tick();
        check_pred("g_b2b");
        #3 arst = 1'b1;
        #1;
        check("g_async_valid", 32'(pred_valid), 32'd0);
        check("g_async_hist",  32'(pred_hist),  32'd0);
        tick();
        check("g_held_valid", 32'(pred_valid), 32'd0);
        lookup_pc = 5'd9;
        #3 arst = 1'b0;
        exp_q.push_back({1'b0, 5'b00000});                          // ctr[9] back to 1
        tick();
        set_idle();
        check_pred("g_first_edge");
        for (int i = 0; i < (1 << INDEX_BITS); i++) begin
            drive_lookup($sformatf("g_init%0d", i), INDEX_BITS'(i), 1'b0, 5'b00000);
        end

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
